vector_writeback: RTL and testbench

Writeback stage of the vector processor: consumes the memory-stage outputs (`wb`, `addervv`, `resALUe`, `resALUve`, `dest`, `memData`), latches them in a one-entry writeback register, and commits them to an 8-entry vector register file and an 8-entry scalar register file on the following cycle. It provides two vector read ports and one scalar read port with bypass from the pending writeback, plus a retired-write counter. It sits between the memory stage and the decode/operand-fetch stage, closing the pipeline loop.

---
 rtl/vector_pkg.sv | 23 ++
 rtl/vector_regfile.sv | 33 +++
 rtl/vector_writeback.sv | 96 +++++++++
 tb/tb_vector_writeback.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector writeback slice.
package vector_pkg;

    localparam int unsigned VW   = 192;
    localparam int unsigned SW   = 21;
    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

    typedef enum logic [1:0] {
        WB_NONE  = 2'b00,
        WB_ADDVV = 2'b01,
        WB_MEM   = 2'b10,
        WB_ALU   = 2'b11
    } wb_code_t;

    typedef struct packed {
        wb_code_t          code;
        logic [AW-1:0]     dest;
        logic [VW-1:0]     vdata;
        logic [SW-1:0]     sdata;
    } wb_entry_t;

endpackage

// File: rtl/vector_regfile.sv
// Register file: one synchronous write port, two combinational read ports, async clear.
module vector_regfile
    import vector_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [W-1:0]  ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [W-1:0]  rb_data
);

    logic [W-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

endmodule

// File: rtl/vector_writeback.sv
// Writeback stage: one-entry writeback register committing to vector and scalar
// register files, with read-port bypass of the pending entry and a retire counter.
module vector_writeback
    import vector_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    wb_in,
    input  logic [AW-1:0] dest_in,
    input  logic [VW-1:0] addervv_in,
    input  logic [VW-1:0] resALUve_in,
    input  logic [SW-1:0] resALUe_in,
    input  logic [VW-1:0] memData_in,
    input  logic [AW-1:0] va_addr,
    input  logic [AW-1:0] vb_addr,
    input  logic [AW-1:0] s_addr,
    output logic [VW-1:0] va_data,
    output logic [VW-1:0] vb_data,
    output logic [SW-1:0] s_data,
    output logic          wb_pending,
    output logic [15:0]   retired
);

    wb_entry_t     pend;
    wb_entry_t     nxt;
    logic          v_we;
    logic          s_we;
    logic [VW-1:0] va_file;
    logic [VW-1:0] vb_file;
    logic [SW-1:0] s_file;
    logic [SW-1:0] s_rb_unused;

    always_comb begin
        nxt = '0;
        if (in_valid && (wb_in != 2'b00)) begin
            nxt.code = wb_code_t'(wb_in);
            nxt.dest = dest_in;
            case (nxt.code)
                WB_ADDVV: nxt.vdata = addervv_in;
                WB_MEM:   nxt.vdata = memData_in;
                WB_ALU: begin
                    nxt.vdata = resALUve_in;
                    nxt.sdata = resALUe_in;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            retired <= '0;
        end else begin
            pend <= nxt;
            if (pend.code != WB_NONE) begin
                retired <= retired + 16'd1;
            end
        end
    end

    assign wb_pending = (pend.code != WB_NONE);
    assign v_we       = wb_pending;
    assign s_we       = (pend.code == WB_ALU);

    vector_regfile #(.W(VW)) u_vrf (
        .clk     (clk),
        .rst     (rst),
        .we      (v_we),
        .waddr   (pend.dest),
        .wdata   (pend.vdata),
        .ra_addr (va_addr),
        .ra_data (va_file),
        .rb_addr (vb_addr),
        .rb_data (vb_file)
    );

    vector_regfile #(.W(SW)) u_srf (
        .clk     (clk),
        .rst     (rst),
        .we      (s_we),
        .waddr   (pend.dest),
        .wdata   (pend.sdata),
        .ra_addr (s_addr),
        .ra_data (s_file),
        .rb_addr (s_addr),
        .rb_data (s_rb_unused)
    );

    // Pending entry is younger than anything in the files, so it always wins.
    assign va_data = (v_we && (va_addr == pend.dest)) ? pend.vdata : va_file;
    assign vb_data = (v_we && (vb_addr == pend.dest)) ? pend.vdata : vb_file;
    assign s_data  = (s_we && (s_addr  == pend.dest)) ? pend.sdata : s_file;

endmodule

// File: tb/tb_vector_writeback.sv
// Scoreboard bench for vector_writeback: issued writes queue expected read-port views
// that a monitor checks while each entry is pending; file contents checked after draining.
module tb_vector_writeback;
    import vector_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    wb_in = '0;
    logic [AW-1:0] dest_in = '0;
    logic [VW-1:0] addervv_in = '0;
    logic [VW-1:0] resALUve_in = '0;
    logic [SW-1:0] resALUe_in = '0;
    logic [VW-1:0] memData_in = '0;
    logic [AW-1:0] va_addr, vb_addr, s_addr;
    logic [VW-1:0] va_data, vb_data;
    logic [SW-1:0] s_data;
    logic          wb_pending;
    logic [15:0]   retired;

    logic          mon_on = 1'b0;
    logic [AW-1:0] mon_va = '0, mon_vb = '0, mon_s = '0;
    logic [AW-1:0] stim_va = '0, stim_vb = '0, stim_s = '0;

    assign va_addr = mon_on ? mon_va : stim_va;
    assign vb_addr = mon_on ? mon_vb : stim_vb;
    assign s_addr  = mon_on ? mon_s  : stim_s;

    typedef struct {
        logic [AW-1:0] dest;
        logic [VW-1:0] v;
        logic [VW-1:0] vb;
        logic [SW-1:0] s;
        logic [15:0]   ret;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [VW-1:0] mv [NREG];
    logic [SW-1:0] ms [NREG];
    logic [15:0]   exp_ret = '0;

    localparam logic [VW-1:0] V_ONE  = 192'h1;
    localparam logic [VW-1:0] V_ONES = {VW{1'b1}};
    localparam logic [VW-1:0] V_A    = 192'hA5A5A5_5A5A5A_123456_789ABC_DEF012_345678_9ABCDE_F0F0F0;
    localparam logic [VW-1:0] V_B    = 192'h0F1E2D_3C4B5A_697887_96A5B4_C3D2E1_F00112_233445_566778;

    vector_writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .wb_in(wb_in), .dest_in(dest_in),
        .addervv_in(addervv_in), .resALUve_in(resALUve_in), .resALUe_in(resALUe_in),
        .memData_in(memData_in), .va_addr(va_addr), .vb_addr(vb_addr), .s_addr(s_addr),
        .va_data(va_data), .vb_data(vb_data), .s_data(s_data),
        .wb_pending(wb_pending), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: whenever an entry is pending, compare bypass, non-bypass and counter views.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && wb_pending) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pending: got 1 expected 0 (no write queued)");
                end else begin
                    e = q.pop_front();
                    mon_va = e.dest;
                    mon_vb = e.dest ^ 3'd1;
                    mon_s  = e.dest;
                    mon_on = 1'b1;
                    #1;
                    chk("bypass_va", va_data, e.v);
                    chk("file_vb", vb_data, e.vb);
                    chk("scalar_s", {171'd0, s_data}, {171'd0, e.s});
                    chk("retired_pending", {176'd0, retired}, {176'd0, e.ret});
                    mon_on = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic v, input logic [1:0] c, input logic [AW-1:0] d,
                         input logic [VW-1:0] av, input logic [VW-1:0] mem,
                         input logic [VW-1:0] alv, input logic [SW-1:0] ale);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v; wb_in = c; dest_in = d;
        addervv_in = av; memData_in = mem; resALUve_in = alv; resALUe_in = ale;
        if (v && c != 2'b00) begin
            e.dest = d;
            e.v    = (c == 2'b01) ? av : (c == 2'b10) ? mem : alv;
            e.vb   = mv[d ^ 3'd1];
            e.s    = (c == 2'b11) ? ale : ms[d];
            e.ret  = exp_ret;
            q.push_back(e);
            mv[d] = e.v;
            if (c == 2'b11) ms[d] = ale;
            exp_ret = exp_ret + 16'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 2'b01, 3'd0, V_ONES, V_ONES, V_ONES, '1);
    endtask

    task automatic check_files(input string tag);
        for (int i = 0; i < NREG; i++) begin
            stim_va = 3'(i); stim_vb = 3'(i); stim_s = 3'(i);
            #1;
            chk({tag, "_va"}, va_data, mv[i]);
            chk({tag, "_vb"}, vb_data, mv[i]);
            chk({tag, "_s"}, {171'd0, s_data}, {171'd0, ms[i]});
        end
        chk({tag, "_retired"}, {176'd0, retired}, {176'd0, exp_ret});
        chk({tag, "_pending"}, {191'd0, wb_pending}, '0);
        chk({tag, "_queue_empty"}, 192'(q.size()), '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < NREG; i++) begin mv[i] = '0; ms[i] = '0; end
        exp_ret = '0;
        q.delete();
        #1;
        check_files("in_reset");
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin mv[i] = '0; ms[i] = '0; end
        rst = 1'b1;
        #12;
        rst = 1'b0;
        check_files("reset");

        // Single addervv write, then a dual vector/scalar write.
        issue(1'b1, 2'b01, 3'd3, V_ONE, V_B, V_A, 21'h0);
        idle(2);
        check_files("addvv");
        issue(1'b1, 2'b11, 3'd5, V_A, V_B, V_ONES, 21'h1ABCD);
        idle(2);
        check_files("alu");

        // Back-to-back memory writes to the same dest: younger wins.
        issue(1'b1, 2'b10, 3'd2, V_ONE, V_A, V_ONES, 21'h0);
        issue(1'b1, 2'b10, 3'd2, V_ONE, V_B, V_ONES, 21'h0);
        issue(1'b1, 2'b01, 3'd3, V_B, V_A, V_ONES, 21'h0);
        issue(1'b1, 2'b11, 3'd2, V_A, V_A, V_B, 21'h155AA);
        idle(2);
        check_files("b2b");

        // Bubbles: code 00 with valid, and code 01 without valid.
        issue(1'b1, 2'b00, 3'd4, V_ONES, V_ONES, V_ONES, '1);
        issue(1'b0, 2'b01, 3'd4, V_ONES, V_ONES, V_ONES, '1);
        issue(1'b0, 2'b11, 3'd6, V_ONES, V_ONES, V_ONES, '1);
        idle(2);
        check_files("bubble");

        // Reset while a write is pending discards it.
        issue(1'b1, 2'b01, 3'd7, V_A, V_B, V_B, 21'h0);
        idle(1);
        do_reset();
        idle(2);
        check_files("rst_pending");

        // Counter wrap: 65535 writes, check, then one more.
        for (int i = 0; i < 65535; i++) begin
            issue(1'b1, 2'b01, 3'(i % 8), VW'(i), V_B, V_A, 21'h0);
        end
        idle(2);
        check_files("ret_ffff");
        issue(1'b1, 2'b11, 3'd6, V_B, V_A, V_ONE, 21'h00F0F);
        idle(2);
        check_files("ret_wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
